// File: rtl/asv_geometry_checker_if.sv
// Stream-side view of the asv_enforcer output bus as seen by asv_geometry_checker.
// The master drives the beat handshake and frame markers; the checker only listens.
interface asv_geometry_checker_if;
  logic tvalid;
  logic tready;
  logic sof_in;
  logic sol_in;
  logic eol_in;
  logic eof_in;

  modport master (output tvalid, tready, sof_in, sol_in, eol_in, eof_in);
  modport slave  (input  tvalid, tready, sof_in, sol_in, eol_in, eof_in);
endinterface

// File: rtl/asv_geometry_checker.sv
// Passive frame-geometry monitor: measures width/height, counts frames, flags protocol errors.
// Optional ASV_GEOM_STRICT_EN adds err[6] when a closed frame is not EXP_W x EXP_H.
module asv_geometry_checker #(
  parameter int W_MAX = 4096,
  parameter int H_MAX = 4096,
  parameter int FC_W  = 16,
  parameter int EXP_W = 16,
  parameter int EXP_H = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  asv_geometry_checker_if.slave        s_axis,
  input  logic                         err_clr,
  output logic                         frame_done,
  output logic [$clog2(W_MAX+1)-1:0]   width_out,
  output logic [$clog2(H_MAX+1)-1:0]   height_out,
  output logic [FC_W-1:0]              frame_count,
`ifdef ASV_GEOM_STRICT_EN
  output logic [6:0]                   err
`else
  output logic [5:0]                   err
`endif
);

  localparam int CW = $clog2(W_MAX + 1);
  localparam int RW = $clog2(H_MAX + 1);
`ifdef ASV_GEOM_STRICT_EN
  localparam int EW = 7;
`else
  localparam int EW = 6;
`endif

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col, w_col_nxt, w_cur_col;
  logic [RW-1:0]   r_row, w_row_nxt, w_cur_row;
  logic            r_first, w_first_nxt, w_cur_first;
  logic [CW-1:0]   r_ref, w_ref_nxt, w_len;
  logic [CW-1:0]   r_width, w_width_nxt;
  logic [RW-1:0]   r_height, w_height_nxt;
  logic [FC_W-1:0] r_fcnt;
  logic            r_done, w_close;
  logic [EW-1:0]   r_err, w_set;
  logic            w_beat;

  assign w_beat = s_axis.tvalid & s_axis.tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_first_nxt  = r_first;
    w_ref_nxt    = r_ref;
    w_width_nxt  = r_width;
    w_height_nxt = r_height;
    w_close      = 1'b0;
    w_set        = '0;
    w_cur_col    = r_col;
    w_cur_row    = r_row;
    w_cur_first  = r_first;
    w_len        = '0;
    if (w_beat) begin
      if (r_state == S_IDLE && !s_axis.sof_in) begin
        w_set[0] = 1'b1;
      end else begin
        w_state_nxt = S_ACTIVE;
        // sof is pixel 0 of line 0: rebase the geometry, then treat the beat like any other
        if (s_axis.sof_in) begin
          if (r_state == S_ACTIVE) w_set[1] = 1'b1;
          w_cur_col   = '0;
          w_cur_row   = '0;
          w_cur_first = 1'b1;
        end else if ((r_col == '0) != s_axis.sol_in) begin
          w_set[2] = 1'b1;
        end
        w_row_nxt   = w_cur_row;
        w_first_nxt = w_cur_first;
        if (s_axis.eol_in) begin
          w_len = (w_cur_col == CW'(W_MAX)) ? CW'(W_MAX) : w_cur_col + CW'(1);
          if (w_cur_first)        w_ref_nxt = w_len;
          else if (w_len != r_ref) w_set[3] = 1'b1;
          w_first_nxt = 1'b0;
          w_col_nxt   = '0;
          if (s_axis.eof_in) begin
            w_close      = 1'b1;
            w_state_nxt  = S_IDLE;
            w_width_nxt  = w_ref_nxt;
            w_height_nxt = (w_cur_row == RW'(H_MAX)) ? RW'(H_MAX) : w_cur_row + RW'(1);
`ifdef ASV_GEOM_STRICT_EN
            if (int'(w_width_nxt) != EXP_W || int'(w_height_nxt) != EXP_H) w_set[6] = 1'b1;
`endif
          end else begin
            if (w_cur_row >= RW'(H_MAX - 1)) w_set[5] = 1'b1;
            w_row_nxt = (w_cur_row == RW'(H_MAX)) ? RW'(H_MAX) : w_cur_row + RW'(1);
          end
        end else begin
          if (s_axis.eof_in) w_set[4] = 1'b1;
          if (w_cur_col >= CW'(W_MAX - 1)) w_set[5] = 1'b1;
          w_col_nxt = (w_cur_col == CW'(W_MAX)) ? CW'(W_MAX) : w_cur_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_col    <= '0;
      r_row    <= '0;
      r_first  <= 1'b0;
      r_ref    <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_fcnt   <= '0;
      r_done   <= 1'b0;
      r_err    <= '0;
    end else begin
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_first  <= w_first_nxt;
      r_ref    <= w_ref_nxt;
      r_width  <= w_width_nxt;
      r_height <= w_height_nxt;
      r_done   <= w_close;
      if (w_close) r_fcnt <= r_fcnt + FC_W'(1);
      // a flag raised on the clearing cycle survives the clear
      r_err    <= (err_clr ? '0 : r_err) | w_set;
    end
  end

  assign frame_done  = r_done;
  assign width_out   = r_width;
  assign height_out  = r_height;
  assign frame_count = r_fcnt;
  assign err         = r_err;

endmodule

// File: tb/tb_asv_geometry_checker.sv
// Directed bench for asv_geometry_checker with small W_MAX/H_MAX so a 16x8 frame sits on both limits.
`timescale 1ns/1ps
module tb_asv_geometry_checker;
  localparam int W_MAX = 16;
  localparam int H_MAX = 8;
  localparam int CW    = $clog2(W_MAX + 1);
  localparam int RW    = $clog2(H_MAX + 1);
`ifdef ASV_GEOM_STRICT_EN
  localparam logic [6:0] SB = 7'h40;
`else
  localparam logic [6:0] SB = 7'h00;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          err_clr = 1'b0;
  logic          frame_done;
  logic [CW-1:0] width_out;
  logic [RW-1:0] height_out;
  logic [15:0]   frame_count;
`ifdef ASV_GEOM_STRICT_EN
  logic [6:0]    err;
`else
  logic [5:0]    err;
`endif
  logic [6:0]    err7;
  assign err7 = 7'(err);

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int snap;
  bit stall_mode = 1'b0;

  asv_geometry_checker_if bus ();

  asv_geometry_checker #(
    .W_MAX(W_MAX), .H_MAX(H_MAX), .FC_W(16), .EXP_W(16), .EXP_H(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(bus), .err_clr(err_clr),
    .frame_done(frame_done), .width_out(width_out), .height_out(height_out),
    .frame_count(frame_count), .err(err)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (frame_done === 1'b1) done_cnt++;

  task automatic set_bus(input logic v, input logic r, input logic sof, input logic sol,
                         input logic eol, input logic eof);
    bus.tvalid = v; bus.tready = r;
    bus.sof_in = sof; bus.sol_in = sol; bus.eol_in = eol; bus.eof_in = eof;
  endtask

  task automatic drive(input logic sof, input logic sol, input logic eol, input logic eof);
    if (stall_mode) begin
      @(negedge aclk);
      set_bus(1'b1, 1'b0, sof, sol, eol, eof);
    end
    @(negedge aclk);
    set_bus(1'b1, 1'b1, sof, sol, eol, eof);
  endtask

  task automatic idle_bus();
    @(negedge aclk);
    set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_line(input int n, input bit first, input bit last, input int eof_at);
    for (int i = 0; i < n; i++)
      drive(first && i == 0, i == 0, i == n - 1, (last && i == n - 1) || i == eof_at);
  endtask

  task automatic send_frame(input int w, input int h);
    for (int r = 0; r < h; r++) send_line(w, r == 0, r == h - 1, -1);
  endtask

  task automatic clear_err();
    @(negedge aclk); err_clr = 1'b1;
    @(negedge aclk); err_clr = 1'b0;
  endtask

  task automatic test_reset();
    set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (width_out !== '0) begin errors++; $display("FAIL reset_width got=%0d exp=0", width_out); end
    checks++; if (height_out !== '0) begin errors++; $display("FAIL reset_height got=%0d exp=0", height_out); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL reset_err got=%h exp=00", err7); end
    aresetn = 1'b1;
  endtask

  task automatic test_clean_frame();
    send_frame(16, 8);
    idle_bus();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL clean_done got=%b exp=1", frame_done); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL clean_width got=%0d exp=16", width_out); end
    checks++; if (height_out !== RW'(8)) begin errors++; $display("FAIL clean_height got=%0d exp=8", height_out); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL clean_count got=%0d exp=1", frame_count); end
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL clean_err got=%h exp=00", err7); end
    @(negedge aclk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL clean_done_pulse got=%b exp=0", frame_done); end
  endtask

  task automatic test_tready_toggle();
    stall_mode = 1'b1;
    send_frame(16, 8);
    stall_mode = 1'b0;
    idle_bus();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL toggle_done got=%b exp=1", frame_done); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL toggle_width got=%0d exp=16", width_out); end
    checks++; if (height_out !== RW'(8)) begin errors++; $display("FAIL toggle_height got=%0d exp=8", height_out); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL toggle_count got=%0d exp=2", frame_count); end
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL toggle_err got=%h exp=00", err7); end
  endtask

  task automatic test_short_line();
    for (int r = 0; r < 8; r++) send_line((r == 2) ? 15 : 16, r == 0, r == 7, -1);
    idle_bus();
    checks++; if (err7 !== 7'h08) begin errors++; $display("FAIL short_err got=%h exp=08", err7); end
    checks++; if (height_out !== RW'(8)) begin errors++; $display("FAIL short_height got=%0d exp=8", height_out); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL short_width got=%0d exp=16", width_out); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL short_count got=%0d exp=3", frame_count); end
    clear_err();
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL short_clr got=%h exp=00", err7); end
  endtask

  task automatic test_pre_sof();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(16, 8);
    idle_bus();
    checks++; if (err7 !== 7'h01) begin errors++; $display("FAIL presof_err got=%h exp=01", err7); end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL presof_count got=%0d exp=4", frame_count); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL presof_width got=%0d exp=16", width_out); end
    clear_err();
  endtask

  task automatic test_mid_sof();
    #1 snap = done_cnt;
    for (int r = 0; r < 4; r++) send_line(16, r == 0, 1'b0, -1);
    send_frame(16, 8);
    idle_bus();
    checks++; if (err7 !== 7'h02) begin errors++; $display("FAIL midsof_err got=%h exp=02", err7); end
    checks++; if (height_out !== RW'(8)) begin errors++; $display("FAIL midsof_height got=%0d exp=8", height_out); end
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL midsof_count got=%0d exp=5", frame_count); end
    @(negedge aclk); #1;
    checks++; if (done_cnt - snap !== 1) begin errors++; $display("FAIL midsof_pulses got=%0d exp=1", done_cnt - snap); end
    clear_err();
  endtask

  task automatic test_col_overflow();
    send_line(18, 1'b1, 1'b1, -1);
    idle_bus();
    checks++; if (err7 !== (7'h20 | SB)) begin errors++; $display("FAIL colovf_err got=%h exp=%h", err7, 7'h20 | SB); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL colovf_width got=%0d exp=16", width_out); end
    checks++; if (height_out !== RW'(1)) begin errors++; $display("FAIL colovf_height got=%0d exp=1", height_out); end
    checks++; if (frame_count !== 16'd6) begin errors++; $display("FAIL colovf_count got=%0d exp=6", frame_count); end
    clear_err();
  endtask

  task automatic test_row_overflow();
    send_frame(16, 9);
    idle_bus();
    checks++; if (err7 !== 7'h20) begin errors++; $display("FAIL rowovf_err got=%h exp=20", err7); end
    checks++; if (height_out !== RW'(8)) begin errors++; $display("FAIL rowovf_height got=%0d exp=8", height_out); end
    checks++; if (frame_count !== 16'd7) begin errors++; $display("FAIL rowovf_count got=%0d exp=7", frame_count); end
    clear_err();
  endtask

  task automatic test_single_beat();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    idle_bus();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", frame_done); end
    checks++; if (width_out !== CW'(1)) begin errors++; $display("FAIL single_width got=%0d exp=1", width_out); end
    checks++; if (height_out !== RW'(1)) begin errors++; $display("FAIL single_height got=%0d exp=1", height_out); end
    checks++; if (frame_count !== 16'd8) begin errors++; $display("FAIL single_count got=%0d exp=8", frame_count); end
    checks++; if (err7 !== SB) begin errors++; $display("FAIL single_err got=%h exp=%h", err7, SB); end
    clear_err();
  endtask

  task automatic test_eof_no_eol();
    send_line(16, 1'b1, 1'b0, 5);
    send_line(16, 1'b0, 1'b1, -1);
    idle_bus();
    checks++; if (err7 !== (7'h10 | SB)) begin errors++; $display("FAIL eofnoeol_err got=%h exp=%h", err7, 7'h10 | SB); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL eofnoeol_width got=%0d exp=16", width_out); end
    checks++; if (height_out !== RW'(2)) begin errors++; $display("FAIL eofnoeol_height got=%0d exp=2", height_out); end
    checks++; if (frame_count !== 16'd9) begin errors++; $display("FAIL eofnoeol_count got=%0d exp=9", frame_count); end
    clear_err();
  endtask

  task automatic test_clr_collision();
    @(negedge aclk);
    set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (err7 !== 7'h01) begin errors++; $display("FAIL collide_err got=%h exp=01", err7); end
    clear_err();
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL collide_clr got=%h exp=00", err7); end
  endtask

`ifdef ASV_GEOM_STRICT_EN
  task automatic test_strict();
    send_frame(16, 7);
    idle_bus();
    checks++; if (err7 !== 7'h40) begin errors++; $display("FAIL strict_err got=%h exp=40", err7); end
    checks++; if (height_out !== RW'(7)) begin errors++; $display("FAIL strict_height got=%0d exp=7", height_out); end
    send_frame(16, 8);
    idle_bus();
    checks++; if (err7 !== 7'h40) begin errors++; $display("FAIL strict_sticky got=%h exp=40", err7); end
    clear_err();
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL strict_clr got=%h exp=00", err7); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    #1 snap = done_cnt;
    for (int r = 0; r < 3; r++) send_line(16, r == 0, 1'b0, -1);
    @(negedge aclk);
    set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", frame_count); end
    checks++; if (width_out !== '0) begin errors++; $display("FAIL midrst_width got=%0d exp=0", width_out); end
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle_bus();
    checks++; if (err7 !== 7'h01) begin errors++; $display("FAIL midrst_err got=%h exp=01", err7); end
    @(negedge aclk); #1;
    checks++; if (done_cnt !== snap) begin errors++; $display("FAIL midrst_pulses got=%0d exp=%0d", done_cnt, snap); end
    clear_err();
  endtask

  task automatic test_back_to_back();
    #1 snap = done_cnt;
    send_frame(16, 8);
    send_frame(16, 8);
    idle_bus();
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", frame_count); end
    checks++; if (width_out !== CW'(16)) begin errors++; $display("FAIL b2b_width got=%0d exp=16", width_out); end
    checks++; if (height_out !== RW'(8)) begin errors++; $display("FAIL b2b_height got=%0d exp=8", height_out); end
    checks++; if (err7 !== 7'h00) begin errors++; $display("FAIL b2b_err got=%h exp=00", err7); end
    @(negedge aclk); #1;
    checks++; if (done_cnt - snap !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", done_cnt - snap); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_tready_toggle();
    test_short_line();
    test_pre_sof();
    test_mid_sof();
    test_col_overflow();
    test_row_overflow();
    test_single_beat();
    test_eof_no_eol();
    test_clr_collision();
`ifdef ASV_GEOM_STRICT_EN
    test_strict();
`endif
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
